// File: rtl/vga_pkg.sv
// Shared timing constants for the VGA raster generator and the colour logic
// that decodes its counters. Default timing is 640x480@60 from 100 MHz.
package vga_pkg;

  localparam int COUNTER_W = 10;
  localparam int COLOR_W   = 4;

  localparam int CLK_DIV_DEF     = 4;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;
  localparam int H_TOTAL_DEF     = 800;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;
  localparam int V_TOTAL_DEF     = 525;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int div_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// Pixel-clock enable: divides clk by CLK_DIV and flags the last system clock
// of each pixel period. With CLK_DIV=1 the divider never leaves 0, so the
// tick is permanently high, including during reset.
module vga_pixel_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_tick
);

  localparam int DIV_W = div_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Divider counts 0..CLK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign pixel_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: raw pixel/line counters (0 = start of sync pulse),
// active-low syncs and a visible-window flag, all aligned to the counters.
// Optional build macro VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [COUNTER_W-1:0] counter_x,
  output logic [COUNTER_W-1:0] counter_y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic                 pixel_tick,
`ifdef VGA_FRAME_COUNT_EN
  output logic [7:0]           frame_count,
`endif
  output logic                 frame_start
);

  localparam logic [COUNTER_W-1:0] H_SYNC_C      = COUNTER_W'(H_SYNC);
  localparam logic [COUNTER_W-1:0] H_ACT_START_C = COUNTER_W'(H_ACT_START);
  localparam logic [COUNTER_W-1:0] H_ACT_END_C   = COUNTER_W'(H_ACT_END);
  localparam logic [COUNTER_W-1:0] H_LAST_C      = COUNTER_W'(H_TOTAL - 1);
  localparam logic [COUNTER_W-1:0] V_SYNC_C      = COUNTER_W'(V_SYNC);
  localparam logic [COUNTER_W-1:0] V_ACT_START_C = COUNTER_W'(V_ACT_START);
  localparam logic [COUNTER_W-1:0] V_ACT_END_C   = COUNTER_W'(V_ACT_END);
  localparam logic [COUNTER_W-1:0] V_LAST_C      = COUNTER_W'(V_TOTAL - 1);

  logic [COUNTER_W-1:0] x_nxt;
  logic [COUNTER_W-1:0] y_nxt;
  logic                 x_last;
  logic                 y_last;

  vga_pixel_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixel_tick)
  );

  // Counter values after the next pixel tick; the decode below uses these so
  // the syncs and video_on change on the same edge as the counters.
  always_comb begin
    x_last = (counter_x == H_LAST_C);
    y_last = (counter_y == V_LAST_C);
    x_nxt  = x_last ? '0 : counter_x + 1'b1;
    y_nxt  = counter_y;
    if (x_last) begin
      y_nxt = y_last ? '0 : counter_y + 1'b1;
    end
  end

  // Advance the raster and register the decoded sync/visible flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_x <= '0;
      counter_y <= '0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      video_on  <= 1'b0;
    end else if (pixel_tick) begin
      counter_x <= x_nxt;
      counter_y <= y_nxt;
      hsync     <= (x_nxt >= H_SYNC_C);
      vsync     <= (y_nxt >= V_SYNC_C);
      video_on  <= (x_nxt >= H_ACT_START_C) && (x_nxt < H_ACT_END_C) &&
                   (y_nxt >= V_ACT_START_C) && (y_nxt < V_ACT_END_C);
    end
  end

  assign frame_start = pixel_tick && (counter_x == '0) && (counter_y == '0);

`ifdef VGA_FRAME_COUNT_EN
  // Frame counter for animation timing; wraps mod 256.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_start) begin
      frame_count <= frame_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing and the divider use
// the 640x480 defaults; the frame is shortened to 6 lines (sync 2, visible
// lines 3..4) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int LINE_CLK  = 3200;
  localparam int NLINES    = 6;
  localparam int FRAME_CLK = LINE_CLK * NLINES;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] counter_x;
  logic [9:0] counter_y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       pixel_tick;
  logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .CLK_DIV     (4),
    .H_SYNC      (96),
    .H_ACT_START (144),
    .H_ACT_END   (784),
    .H_TOTAL     (800),
    .V_SYNC      (2),
    .V_ACT_START (3),
    .V_ACT_END   (5),
    .V_TOTAL     (NLINES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .counter_x   (counter_x),
    .counter_y   (counter_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .pixel_tick  (pixel_tick),
`ifdef VGA_FRAME_COUNT_EN
    .frame_count (frame_count),
`endif
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (10) step();
    checks++;
    if ({counter_x, counter_y} !== 20'd0) begin
      errors++;
      $display("FAIL reset_counters: got x=%0d y=%0d, want 0 0", counter_x, counter_y);
    end
    checks++;
    if ({hsync, vsync, video_on, pixel_tick, frame_start} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got hs=%b vs=%b von=%b tick=%b fs=%b, want all 0",
               hsync, vsync, video_on, pixel_tick, frame_start);
    end
  endtask

  // After reset release: tick and frame_start at clk 3, counter_x=1 at clk 4.
  task automatic test_first_tick(input string tag);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (pixel_tick !== ((k % 4) == 3)) begin
        errors++;
        $display("FAIL %s_tick clk%0d: got %b, want %b", tag, k, pixel_tick, (k % 4) == 3);
      end
      checks++;
      if (frame_start !== (k == 3)) begin
        errors++;
        $display("FAIL %s_frame_start clk%0d: got %b, want %b", tag, k, frame_start, k == 3);
      end
      checks++;
      if (counter_x !== 10'(k / 4)) begin
        errors++;
        $display("FAIL %s_counter_x clk%0d: got %0d, want %0d", tag, k, counter_x, k / 4);
      end
    end
  endtask

  task automatic test_line();
    int n = 0;
    int y0, hs_low, ticks, seq_err, maxx, prev_x, exp_x;
    while (!(pixel_tick === 1'b1 && counter_x === 10'd0) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if (!(pixel_tick === 1'b1 && counter_x === 10'd0)) begin
      errors++;
      $display("FAIL line_start_wait: no line start within %0d clk (x=%0d)", n, counter_x);
    end
    y0 = counter_y;
    hs_low = 0; ticks = 0; seq_err = 0; maxx = 0; prev_x = 0;
    for (int i = 0; i < LINE_CLK; i++) begin
      step();
      if (hsync === 1'b0) hs_low++;
      if (pixel_tick === 1'b1) ticks++;
      if (int'(counter_x) > maxx) maxx = counter_x;
      if (int'(counter_x) != prev_x) begin
        exp_x = (prev_x == 799) ? 0 : prev_x + 1;
        if (int'(counter_x) != exp_x) seq_err++;
        prev_x = counter_x;
      end
    end
    checks++;
    if (hs_low != 384) begin
      errors++;
      $display("FAIL line_hsync_low: got %0d clk, want 384", hs_low);
    end
    checks++;
    if (ticks != 800) begin
      errors++;
      $display("FAIL line_ticks: got %0d, want 800", ticks);
    end
    checks++;
    if (seq_err != 0 || maxx != 799) begin
      errors++;
      $display("FAIL line_x_sequence: got %0d steps wrong max=%0d, want 0 wrong max=799", seq_err, maxx);
    end
    checks++;
    if (counter_x !== 10'd0 || int'(counter_y) != (y0 + 1) % NLINES || pixel_tick !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap: got x=%0d y=%0d tick=%b, want x=0 y=%0d tick=1",
               counter_x, counter_y, pixel_tick, (y0 + 1) % NLINES);
    end
  endtask

  task automatic test_frame();
    int n = 0;
    int fs, vs_low, maxy, von_ticks, rises, rise_x, rise_y, fall_x, fall_y;
    logic prev_von;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] fc0;
`endif
    while (frame_start !== 1'b1 && n < FRAME_CLK + 100) begin
      step();
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_wait: no frame_start within %0d clk", n);
    end
`ifdef VGA_FRAME_COUNT_EN
    fc0 = frame_count;
`endif
    fs = 0; vs_low = 0; maxy = 0; von_ticks = 0; rises = 0;
    rise_x = -1; rise_y = -1; fall_x = -1; fall_y = -1;
    prev_von = video_on;
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      if (frame_start === 1'b1) fs++;
      if (vsync === 1'b0) vs_low++;
      if (int'(counter_y) > maxy) maxy = counter_y;
      if (pixel_tick === 1'b1 && video_on === 1'b1) von_ticks++;
      if (video_on === 1'b1 && prev_von !== 1'b1) begin
        rises++;
        if (rise_x < 0) begin rise_x = counter_x; rise_y = counter_y; end
      end
      if (video_on !== 1'b1 && prev_von === 1'b1 && fall_x < 0) begin
        fall_x = counter_x; fall_y = counter_y;
      end
      prev_von = video_on;
    end
    checks++;
    if (fs != 1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_start_count: got %0d pulses (end fs=%b), want 1 pulse at frame end", fs, frame_start);
    end
    checks++;
    if (vs_low != 2 * LINE_CLK) begin
      errors++;
      $display("FAIL frame_vsync_low: got %0d clk, want %0d", vs_low, 2 * LINE_CLK);
    end
    checks++;
    if (maxy != NLINES - 1) begin
      errors++;
      $display("FAIL frame_max_y: got %0d, want %0d", maxy, NLINES - 1);
    end
    checks++;
    if (von_ticks != 1280) begin
      errors++;
      $display("FAIL frame_visible_ticks: got %0d, want 1280", von_ticks);
    end
    checks++;
    if (rise_x != 144 || rise_y != 3 || rises != 2) begin
      errors++;
      $display("FAIL frame_video_rise: got (%0d,%0d) x%0d, want (144,3) x2", rise_x, rise_y, rises);
    end
    checks++;
    if (fall_x != 784 || fall_y != 3) begin
      errors++;
      $display("FAIL frame_video_fall: got (%0d,%0d), want (784,3)", fall_x, fall_y);
    end
`ifdef VGA_FRAME_COUNT_EN
    checks++;
    if (frame_count !== fc0 + 8'd1) begin
      errors++;
      $display("FAIL frame_count_inc: got %0d, want %0d", frame_count, fc0 + 8'd1);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(counter_x === 10'd500 && counter_y === 10'd4) && n < FRAME_CLK + 100) begin
      step();
      n++;
    end
    checks++;
    if (!(counter_x === 10'd500 && counter_y === 10'd4)) begin
      errors++;
      $display("FAIL mid_wait: did not reach (500,4), got (%0d,%0d)", counter_x, counter_y);
    end
    checks++;
    if ({hsync, vsync, video_on} !== 3'b111) begin
      errors++;
      $display("FAIL mid_before: got hs=%b vs=%b von=%b at (500,4), want 1 1 1", hsync, vsync, video_on);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({counter_x, counter_y} !== 20'd0 || {hsync, vsync, video_on, pixel_tick} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b, want 0 0 0 0 0 0",
               counter_x, counter_y, hsync, vsync, video_on, pixel_tick);
    end
    step();
    test_first_tick("mid");
  endtask

  initial begin
    test_reset();
    test_first_tick("pwrup");
    test_line();
    test_frame();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
